// File: rtl/qoi_types.sv
// Shared QOI types: pixel/index/size/bus types, opcode constants and decoder states.
package qoi_types;

  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  addr_t;
  typedef logic [5:0]  index_t;
  typedef logic [29:0] size_t;

  typedef struct packed {
    byte_t r;
    byte_t g;
    byte_t b;
    byte_t a;
  } pixel_t;

  localparam byte_t QOI_OP_INDEX = 8'h00;
  localparam byte_t QOI_OP_DIFF  = 8'h40;
  localparam byte_t QOI_OP_LUMA  = 8'h80;
  localparam byte_t QOI_OP_RUN   = 8'hC0;
  localparam byte_t QOI_OP_RGB   = 8'hFE;
  localparam byte_t QOI_OP_RGBA  = 8'hFF;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_FETCH,
    DEC_ARG,
    DEC_EMIT
  } dec_state_t;

  // Channel k of a pixel in stream order r, g, b, a.
  function automatic byte_t px_byte(input pixel_t p, input logic [1:0] k);
    case (k)
      2'd0:    return p.r;
      2'd1:    return p.g;
      2'd2:    return p.b;
      default: return p.a;
    endcase
  endfunction

  function automatic pixel_t px_set(input pixel_t p, input logic [1:0] k, input byte_t v);
    pixel_t q;
    q = p;
    case (k)
      2'd0:    q.r = v;
      2'd1:    q.g = v;
      2'd2:    q.b = v;
      default: q.a = v;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/qoi_hash.sv
// QOI index hash (3r + 5g + 7b + 11a) mod 64; shared by encoder and decoder.
module qoi_hash
  import qoi_types::*;
(
  input  pixel_t px,
  output index_t idx
);

  assign idx = index_t'(px.r * 8'd3 + px.g * 8'd5 + px.b * 8'd7 + px.a * 8'd11);

endmodule

// File: rtl/qoi_decoder.sv
// Memory-mapped QOI decompressor: CPU pushes chunk bytes to reg 0 and reads
// decoded pixels back from reg 0 as r, g, b, a.
module qoi_decoder
  import qoi_types::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cs,
  input  logic  we,
  input  byte_t data_i,
  output byte_t data_o,
  input  addr_t addr
);

  dec_state_t state;
  size_t      size;
  size_t      count;
  logic       done;
  logic [5:0] run;
  logic [1:0] byte_idx;
  logic [1:0] arg_idx;
  logic [1:0] arg_last;
  byte_t      op;
  pixel_t     prev_px;
  pixel_t     px;
  pixel_t     index_mem [64];

  logic   wr0, rd0, start_wr;
  logic   emit_go;
  pixel_t new_px;
  logic [5:0] new_run;
  index_t new_hash;
  byte_t  dg;

  assign wr0      = cs && we && (addr == 3'd0);
  assign rd0      = cs && !we && (addr == 3'd0);
  assign start_wr = cs && we && (addr == 3'd3) && data_i[7];

  // Pixel produced by the chunk byte being written this cycle, if any.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    new_px  = prev_px;
    new_run = 6'd0;
    emit_go = 1'b0;
    // NOTE: combinational logic uses blocking '='; registers below use '<=' only.
    dg      = {2'b00, op[5:0]} - 8'd32;
    if (wr0 && state == DEC_FETCH && data_i != QOI_OP_RGB && data_i != QOI_OP_RGBA) begin
      case (data_i[7:6])
        2'b00: begin
          new_px  = index_mem[data_i[5:0]];
          emit_go = 1'b1;
        end
        2'b01: begin
          new_px.r = prev_px.r + {6'd0, data_i[5:4]} - 8'd2;
          new_px.g = prev_px.g + {6'd0, data_i[3:2]} - 8'd2;
          new_px.b = prev_px.b + {6'd0, data_i[1:0]} - 8'd2;
          emit_go  = 1'b1;
        end
        2'b11: begin
          new_run = data_i[5:0];
          emit_go = 1'b1;
        end
        default: ;
      endcase
    end else if (wr0 && state == DEC_ARG) begin
      if (op[7:6] == 2'b10) begin
        new_px.r = prev_px.r + dg + {4'd0, data_i[7:4]} - 8'd8;
        new_px.g = prev_px.g + dg;
        new_px.b = prev_px.b + dg + {4'd0, data_i[3:0]} - 8'd8;
        emit_go  = 1'b1;
      end else if (arg_idx == arg_last) begin
        new_px  = px_set(px, arg_idx, data_i);
        emit_go = 1'b1;
      end
    end
  end

  qoi_hash u_hash (
    .px  (new_px),
    .idx (new_hash)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DEC_IDLE;
      size     <= '0;
      count    <= '0;
      done     <= 1'b0;
      run      <= '0;
      byte_idx <= '0;
      arg_idx  <= '0;
      arg_last <= '0;
      op       <= '0;
      prev_px  <= '0;
      px       <= '0;
      // NOTE: the index lives in flops and must start from zero, so it is reset explicitly.
      for (int i = 0; i < 64; i++) index_mem[i] <= '0;
    end else begin
      case (state)
        DEC_IDLE: begin
          if (cs && we) begin
            case (addr)
              3'd4: size[7:0]   <= data_i;
              3'd5: size[15:8]  <= data_i;
              3'd6: size[23:16] <= data_i;
              3'd7: size[29:24] <= data_i[5:0];
              default: ;
            endcase
          end
          if (start_wr) begin
            count    <= '0;
            run      <= '0;
            byte_idx <= '0;
            prev_px  <= '0;
            for (int i = 0; i < 64; i++) index_mem[i] <= '0;
            done     <= (size == '0);
            state    <= (size == '0) ? DEC_IDLE : DEC_FETCH;
          end
        end
        DEC_FETCH: begin
          if (wr0) begin
            op <= data_i;
            if (!emit_go) begin
              state    <= DEC_ARG;
              arg_idx  <= '0;
              px       <= prev_px;
              arg_last <= (data_i == QOI_OP_RGBA) ? 2'd3 :
                          (data_i == QOI_OP_RGB)  ? 2'd2 : 2'd0;
            end
          end
        end
        DEC_ARG: begin
          if (wr0 && !emit_go) begin
            px      <= px_set(px, arg_idx, data_i);
            arg_idx <= arg_idx + 2'd1;
          end
        end
        DEC_EMIT: begin
          if (rd0) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              count <= count + 30'd1;
              if (count + 30'd1 == size) begin
                state <= DEC_IDLE;
                done  <= 1'b1;
                run   <= '0;
              end else if (run != '0) begin
                run <= run - 6'd1;
              end else begin
                state <= DEC_FETCH;
              end
            end
          end
        end
        default: state <= DEC_IDLE;
      endcase

      if (emit_go) begin
        px                 <= new_px;
        prev_px            <= new_px;
        index_mem[new_hash] <= new_px;
        run                <= new_run;
        state              <= DEC_EMIT;
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (addr)
      3'd0: if (state == DEC_EMIT) data_o = px_byte(px, byte_idx);
      3'd3: data_o = {state != DEC_IDLE, done, 2'b00, byte_idx,
                      state == DEC_EMIT, state == DEC_FETCH || state == DEC_ARG};
      3'd4: data_o = count[7:0];
      3'd5: data_o = count[15:8];
      3'd6: data_o = count[23:16];
      3'd7: data_o = {2'b00, count[29:24]};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// Scoreboard bench for qoi_decoder: expected pixel bytes are queued as chunks
// are written and compared as the CPU reads them back.
module tb_qoi_decoder;
  import qoi_types::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  cs  = 1'b0;
  logic  we  = 1'b0;
  byte_t data_i = '0;
  byte_t data_o;
  addr_t addr = '0;

  int checks = 0;
  int errors = 0;
  byte_t exp_q[$];

  qoi_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .data_i (data_i),
    .data_o (data_o),
    .addr   (addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input addr_t a, input byte_t d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(posedge clk);
    #1 cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input addr_t a, output byte_t d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = data_o;
    @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic start_job(input logic [29:0] n);
    bus_wr(3'd4, n[7:0]);
    bus_wr(3'd5, n[15:8]);
    bus_wr(3'd6, n[23:16]);
    bus_wr(3'd7, {2'b00, n[29:24]});
    bus_wr(3'd3, 8'h80);
  endtask

  task automatic push_px(input logic [31:0] p);
    for (int k = 0; k < 4; k++) exp_q.push_back(p[31-8*k -: 8]);
  endtask

  task automatic wait_ready();
    byte_t st;
    logic  ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      bus_rd(3'd3, st);
      if (st[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_bytes(input int n);
    byte_t d, e;
    for (int k = 0; k < n; k++) begin
      bus_rd(3'd0, d);
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("px_byte", {24'd0, d}, {24'd0, e});
      end
    end
  endtask

  task automatic drain(input int npx);
    for (int p = 0; p < npx; p++) begin
      wait_ready();
      drain_bytes(4);
    end
  endtask

  task automatic check_reg(input string tag, input addr_t a, input byte_t exp);
    byte_t d;
    bus_rd(a, d);
    check(tag, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic check_count(input logic [29:0] exp);
    byte_t b0, b1, b2, b3;
    bus_rd(3'd4, b0);
    bus_rd(3'd5, b1);
    bus_rd(3'd6, b2);
    bus_rd(3'd7, b3);
    check("count", {b3, b2, b1, b0}, {2'b00, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check_reg("rst_reg0", 3'd0, 8'h00);
    check_reg("rst_status", 3'd3, 8'h00);
    check_reg("rst_cnt4", 3'd4, 8'h00);
    check_reg("rst_cnt5", 3'd5, 8'h00);
    check_reg("rst_cnt6", 3'd6, 8'h00);
    check_reg("rst_cnt7", 3'd7, 8'h00);

    // Empty job completes immediately.
    start_job(30'd0);
    check_reg("size0_status", 3'd3, 8'h40);

    // Single RGB pixel, with byte-index visibility mid-pixel.
    start_job(30'd1);
    check_reg("fetch_status", 3'd3, 8'h81);
    check_reg("fetch_reg0", 3'd0, 8'h00);
    check_reg("fetch_status2", 3'd3, 8'h81);
    bus_wr(3'd0, 8'hFE); bus_wr(3'd0, 8'h10);
    check_reg("arg_status", 3'd3, 8'h81);
    bus_wr(3'd0, 8'h20); bus_wr(3'd0, 8'h30);
    push_px(32'h10203000);
    check_reg("emit_status", 3'd3, 8'h82);
    drain_bytes(1);
    check_reg("emit_idx1", 3'd3, 8'h86);
    drain_bytes(3);
    check_reg("rgb_done", 3'd3, 8'h40);
    check_count(30'd1);

    // RGBA then DIFF +1.
    start_job(30'd2);
    bus_wr(3'd0, 8'hFF); bus_wr(3'd0, 8'h01); bus_wr(3'd0, 8'h02);
    bus_wr(3'd0, 8'h03); bus_wr(3'd0, 8'h04);
    push_px(32'h01020304);
    drain(1);
    bus_wr(3'd0, 8'h7F);
    push_px(32'h02030404);
    drain(1);
    check_reg("diff_done", 3'd3, 8'h40);
    check_count(30'd2);

    // LUMA from 10 20 30 00.
    start_job(30'd2);
    bus_wr(3'd0, 8'hFE); bus_wr(3'd0, 8'h10); bus_wr(3'd0, 8'h20); bus_wr(3'd0, 8'h30);
    push_px(32'h10203000);
    drain(1);
    bus_wr(3'd0, 8'hA2); bus_wr(3'd0, 8'h9A);
    push_px(32'h13223400);
    drain(1);
    check_reg("luma_done", 3'd3, 8'h40);

    // INDEX lookup, then a run truncated by the size limit.
    start_job(30'd4);
    bus_wr(3'd0, 8'hFE); bus_wr(3'd0, 8'h10); bus_wr(3'd0, 8'h20); bus_wr(3'd0, 8'h30);
    push_px(32'h10203000);
    drain(1);
    bus_wr(3'd0, 8'hFE); bus_wr(3'd0, 8'h00); bus_wr(3'd0, 8'h00); bus_wr(3'd0, 8'h00);
    push_px(32'h00000000);
    drain(1);
    bus_wr(3'd0, 8'h20);
    push_px(32'h10203000);
    drain(1);
    bus_wr(3'd0, 8'hC5);
    push_px(32'h10203000);
    drain(1);
    check_reg("trunc_done", 3'd3, 8'h40);
    check_reg("trunc_reg0", 3'd0, 8'h00);
    check_count(30'd4);

    // Run that repeats: C1 yields two copies.
    start_job(30'd3);
    bus_wr(3'd0, 8'hFE); bus_wr(3'd0, 8'h01); bus_wr(3'd0, 8'h02); bus_wr(3'd0, 8'h03);
    push_px(32'h01020300);
    drain(1);
    bus_wr(3'd0, 8'hC1);
    push_px(32'h01020300);
    push_px(32'h01020300);
    drain(2);
    check_reg("run_done", 3'd3, 8'h40);
    check_count(30'd3);

    // DIFF -2 wraps modulo 256 from a cleared previous pixel.
    start_job(30'd1);
    bus_wr(3'd0, 8'h40);
    push_px(32'hFEFEFE00);
    drain(1);
    check_reg("wrap_done", 3'd3, 8'h40);

    // Reset in the middle of an RGBA argument sequence.
    start_job(30'd1);
    bus_wr(3'd0, 8'hFF); bus_wr(3'd0, 8'h01);
    do_reset();
    check_reg("abort_status", 3'd3, 8'h00);
    check_reg("abort_reg0", 3'd0, 8'h00);
    check_count(30'd0);
    start_job(30'd1);
    bus_wr(3'd0, 8'hFE); bus_wr(3'd0, 8'h05); bus_wr(3'd0, 8'h06); bus_wr(3'd0, 8'h07);
    push_px(32'h05060700);
    drain(1);
    check_reg("post_abort_done", 3'd3, 8'h40);

    check("sb_left", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qoi_decoder.md
# qoi_decoder

Memory-mapped QOI decompressor peripheral on the 6502 bus; inverse of the team's QOI encoder. The CPU starts a job with a pixel count, pushes encoded chunk bytes into register 0, and reads decoded pixels back from register 0 as r, g, b, a byte sequences. Decoder state (previous pixel, 64-entry index, run counter) resets exactly as in the encoder, so encoder output decodes bit-exactly.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cs  in  1  chip select
- we  in  1  1 = CPU write, 0 = CPU read (qualified by cs)
- data_i  in  byte_t  CPU write data
- data_o  out  byte_t  CPU read data, combinational from addr
- addr  in  addr_t (3 bits)  register select

## Operation
- Register map, write side:
  - 0: encoded byte (FETCH/ARG only).
  - 3: bit7 start.
  - 4..7: size[29:0], little-endian (reg 7 bits 5:0).
- Register map, read side:
  - 0: current pixel byte (EMIT only), else 0x00.
  - 3: status. bit7 busy (state != IDLE), bit6 done (sticky), bits3:2 byte index, bit1 pixel_ready (EMIT), bit0 byte_req (FETCH/ARG).
  - 4..7: count[29:0].
  - 1, 2: read 0x00.
- States: IDLE, FETCH, ARG, EMIT.
- IDLE + start write:
  - clears count, done, run, byte index and all 64 index entries; prev_px <= {0,0,0,0}.
  - size == 0: stay IDLE, set done. Otherwise go to FETCH.
- FETCH: a write to reg 0 latches the opcode.
  - 0xFE (RGB, 3 args) or 0xFF (RGBA, 4 args): go to ARG.
  - 10gggggg (LUMA, 1 arg): go to ARG.
  - 00iiiiii (INDEX): px = index[i]; go to EMIT.
  - 01rrggbb (DIFF): each channel += field-2; a unchanged; go to EMIT.
  - 11nnnnnn (RUN, not FE/FF): px = prev_px; run = n; go to EMIT.
- ARG: each reg-0 write fills the next argument byte; after the last one, go to EMIT.
  - RGB: a = prev a.
  - LUMA: dg = g6-32; arg = {dr_dg, db_dg}, each biased by 8; dr = dr_dg + dg, db = db_dg + dg.
- All channel arithmetic is mod 256. Signed deltas are computed 9-bit and truncated.
- On entry to EMIT: prev_px <= px; index[hash(px)] <= px, where hash = (3r + 5g + 7b + 11a) mod 64.
- EMIT: each reg-0 read (cs & ~we) returns px byte[byte index] in order r, g, b, a, then byte index increments. After the 4th read:
  - count++ and byte index <= 0.
  - count == size: go to IDLE, set done, drop any remaining run.
  - run > 0: run--, stay in EMIT (same pixel).
  - Otherwise: go to FETCH.
- Reg-0 writes outside FETCH/ARG and reg-0 reads outside EMIT are ignored with no side effect.
- Start while busy is ignored. Size writes while busy are ignored.

## Timing
- Reset values: state IDLE, count 0, done 0, run 0, byte index 0, prev_px 0, index array 0. data_o reads 0x00 for every addr.
- One byte is consumed per qualifying write cycle. The state advances on that clock edge.
- pixel_ready asserts in the cycle after the final chunk byte is written (1-cycle latency).
- Read side effects occur once per cycle with cs & ~we & addr==0. A multi-cycle read strobe counts each cycle; the CPU interface guarantees a single-cycle strobe.
- rst mid-job aborts immediately to reset values. No partial pixel is retained.
- A start write and a reg-0 access never occur in the same cycle; only one addr is presented per cycle.

## Structure
- Add to qoi_types:
  - opcode constants QOI_OP_INDEX, QOI_OP_DIFF, QOI_OP_LUMA, QOI_OP_RUN, QOI_OP_RGB, QOI_OP_RGBA.
  - dec_state_t.
  - Reuse of pixel_t, index_t, size_t, byte_t, addr_t.
- Sub-module qoi_hash: combinational pixel_t -> index_t, shared with the encoder.
- Index array in flops: 64 x 32 bits, cleared on start and on rst.

## Test plan
- Reset: reads of regs 0, 3, 4-7 all return 0x00.
- size=1, start, write FE 10 20 30 -> reads 10 20 30 00; status 0x40; count=1.
- size=2: FF 01 02 03 04 -> 01 02 03 04; then 0x7F (DIFF +1,+1,+1) -> 02 03 04 04; done set.
- LUMA from prev 10 20 30 00: write A2 9A -> 13 22 34 00.
- size=4: FE 10 20 30, FE 00 00 00, then 0x20 (INDEX 32) -> third pixel 10 20 30 00; then C5 (run 6) -> one pixel emitted, truncated at size=4, done.
- Assert rst during ARG after FF 01 -> status 0x00; a new start plus FE 05 06 07 decodes 05 06 07 00.
